// File: rtl/timer_pkg.sv
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types and timebase constants for the tick timer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  typedef enum logic {PERIODIC = 1'b0, ONESHOT = 1'b1} timer_mode_e;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} timer_state_e;

  localparam int unsigned CLK_HZ     = 125_000_000;
  localparam int unsigned TICKS_10MS = CLK_HZ / 100;
  localparam int unsigned TICKS_1S   = CLK_HZ;

endpackage : timer_pkg

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
//  Module      : tick_prescaler
//  Description : Wrapping divide-by-(div+1) counter; step marks the last cycle
//                of each prescaler period while enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic [PRESC_WIDTH-1:0] div,
  output logic                   step
);

  logic [PRESC_WIDTH-1:0] presc_cnt;

  // step is combinational so the owning counter advances on the same edge
  // the prescaler wraps; with div = 0 it is high on every enabled cycle.
  assign step = en && (presc_cnt == div);

  // Prescaler counter: cleared on (re)start/stop, counts 0..div while enabled.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc_cnt <= '0;
    end else if (en) begin
      if (step) presc_cnt <= '0;
      else      presc_cnt <= presc_cnt + 1'b1;
    end
  end

endmodule : tick_prescaler

`default_nettype wire

// File: rtl/tick_timer.sv
// ============================================================================
//  Module      : tick_timer
//  Description : Programmable periodic / one-shot timebase with prescaler,
//                start/stop control, latched settings and a one-cycle done
//                pulse at every period boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_timer
  import timer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   mode,
  input  logic [WIDTH-1:0]       count_lim,
  input  logic [PRESC_WIDTH-1:0] presc_div,
  output logic [WIDTH-1:0]       count,
  output logic                   done,
  output logic                   busy
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  timer_state_e           state, state_n;
  timer_mode_e            mode_q;
  logic [WIDTH-1:0]       lim_q;
  logic [PRESC_WIDTH-1:0] div_q;
  logic [WIDTH-1:0]       count_n;
  logic                   done_n;
  logic                   latch;
  logic                   presc_clr;
  logic                   step;

  tick_prescaler #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .en   (state == RUN),
    .div  (div_q),
    .step (step)
  );

  // Next-state logic: stop beats start, start beats counting, so an aborted
  // or restarted period never produces a done even on a boundary edge.
  always_comb begin
    state_n   = state;
    count_n   = count;
    done_n    = 1'b0;
    latch     = 1'b0;
    presc_clr = 1'b0;
    if (stop) begin
      if (state == RUN) begin
        state_n   = IDLE;
        count_n   = '0;
        presc_clr = 1'b1;
      end
    end else if (start && (count_lim != '0)) begin
      latch     = 1'b1;
      state_n   = RUN;
      count_n   = '0;
      presc_clr = 1'b1;
    end else if ((state == RUN) && step) begin
      if (count == lim_q - ONE) begin
        count_n = '0;
        done_n  = 1'b1;
        if (mode_q == ONESHOT) state_n = IDLE;
      end else begin
        count_n = count + ONE;
      end
    end
  end

  // State, count and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      done  <= done_n;
      busy  <= (state_n == RUN);
    end
  end

  // Settings are captured only by an accepted start and held until the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      lim_q  <= '0;
      div_q  <= '0;
      mode_q <= PERIODIC;
    end else if (latch) begin
      lim_q  <= count_lim;
      div_q  <= presc_div;
      mode_q <= timer_mode_e'(mode);
    end
  end

endmodule : tick_timer

`default_nettype wire

// File: tb/tb_tick_timer.sv
// ============================================================================
//  Module      : tb_tick_timer
//  Description : Directed self-checking bench for tick_timer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_timer;

  localparam int WIDTH       = 32;
  localparam int PRESC_WIDTH = 8;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic                   stop;
  logic                   mode;
  logic [WIDTH-1:0]       count_lim;
  logic [PRESC_WIDTH-1:0] presc_div;
  logic [WIDTH-1:0]       count;
  logic                   done;
  logic                   busy;

  int n_checks = 0;
  int n_fail   = 0;

  tick_timer #(
    .WIDTH       (WIDTH),
    .PRESC_WIDTH (PRESC_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .count_lim (count_lim),
    .presc_div (presc_div),
    .count     (count),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present settings with start for exactly one edge (that edge is "edge 0").
  task automatic do_start(input logic [31:0] lim, input logic [7:0] div, input logic m);
    count_lim = lim;
    presc_div = div;
    mode      = m;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] c, input logic d, input logic b);
    check({tag, ".count"}, count, c);
    check({tag, ".done"},  {31'd0, done}, {31'd0, d});
    check({tag, ".busy"},  {31'd0, busy}, {31'd0, b});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    count_lim = '0; presc_div = '0;

    // Reset held for three edges, then released.
    repeat (3) tick();
    check_state("reset", 0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    check_state("post_reset", 0, 1'b0, 1'b0);

    // PERIODIC lim=4 div=0: count 1,2,3,0 with done on every 4th edge.
    do_start(4, 0, 1'b0);
    check_state("per4_e0", 0, 1'b0, 1'b1);
    for (int e = 1; e <= 12; e++) begin
      tick();
      check_state($sformatf("per4_e%0d", e), e % 4, (e % 4) == 0, 1'b1);
    end

    // Reset mid-run with lim=10: back to idle, no done.
    do_start(10, 0, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_state("rst_mid", 0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      check_state("rst_idle", 0, 1'b0, 1'b0);
    end

    // ONESHOT lim=5 div=2: one step every 3 cycles, single done after edge 15.
    do_start(5, 2, 1'b1);
    check_state("one_e0", 0, 1'b0, 1'b1);
    for (int e = 1; e <= 15; e++) begin
      tick();
      check_state($sformatf("one_e%0d", e), (e == 15) ? 0 : e / 3, e == 15, e < 15);
    end
    for (int e = 0; e < 50; e++) begin
      tick();
      check_state("one_after", 0, 1'b0, 1'b0);
    end

    // Start with lim=0 is ignored.
    do_start(0, 0, 1'b0);
    for (int e = 0; e < 20; e++) begin
      check_state("lim0", 0, 1'b0, 1'b0);
      tick();
    end

    // PERIODIC lim=1 div=0: done continuously high.
    do_start(1, 0, 1'b0);
    check_state("lim1_e0", 0, 1'b0, 1'b1);
    for (int e = 1; e <= 6; e++) begin
      tick();
      check_state("lim1", 0, 1'b1, 1'b1);
    end

    // PERIODIC lim=8 (restart from the lim=1 run), then stop after edge 5.
    do_start(8, 0, 1'b0);
    check_state("stop_e0", 0, 1'b0, 1'b1);
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_state("stop_run", e, 1'b0, 1'b1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_state("stopped", 0, 1'b0, 1'b0);
    for (int e = 0; e < 10; e++) begin
      tick();
      check_state("stop_idle", 0, 1'b0, 1'b0);
    end

    // start and stop on the same edge from IDLE: stays idle.
    stop = 1'b1;
    do_start(8, 0, 1'b0);
    stop = 1'b0;
    check_state("ss_same", 0, 1'b0, 1'b0);
    for (int e = 0; e < 10; e++) begin
      tick();
      check_state("ss_idle", 0, 1'b0, 1'b0);
    end

    // Restart: lim=6 run, restart at edge 4 with lim=3 -> done after edge 7.
    do_start(6, 0, 1'b0);
    for (int e = 1; e <= 3; e++) begin
      tick();
      check_state("rs6", e, 1'b0, 1'b1);
    end
    do_start(3, 0, 1'b0);
    check_state("rs_e4", 0, 1'b0, 1'b1);
    for (int e = 5; e <= 7; e++) begin
      tick();
      check_state($sformatf("rs3_e%0d", e), (e - 4) % 3, e == 7, 1'b1);
    end
    tick();
    tick();
    check_state("rs3_e9", 2, 1'b0, 1'b1);
    // Restart on what would be a boundary edge (edge 10): no done.
    do_start(3, 0, 1'b0);
    check_state("rs_bound", 0, 1'b0, 1'b1);

    // Changing count_lim without start leaves the period at 3.
    count_lim = 2;
    for (int e = 11; e <= 16; e++) begin
      tick();
      check_state($sformatf("noload_e%0d", e), (e - 10) % 3, ((e - 10) % 3) == 0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule : tb_tick_timer

`default_nettype wire
